in_feeder: RTL and testbench

IN_FEEDER -- requirements
Module: in_feeder

---
 rtl/in_feeder_if.sv | 29 ++
 rtl/in_feeder.sv | 109 ++++++++++
 tb/tb_in_feeder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/in_feeder_if.sv
// Input-side bus of the in_feeder: per-port producer streams plus the processor read port.
// The producer/processor side holds the master modport and the feeder holds the slave modport.
interface in_feeder_if #(
  parameter int NBITS = 19,
  parameter int NPORT = 4,
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NPORT*NBITS-1:0] s_data;
  logic [NPORT-1:0]       s_valid;
  logic [NPORT-1:0]       s_ready;
  logic [NPORT-1:0]       req_in;
  logic [NBITS-1:0]       io_in;
  logic [NPORT-1:0]       underflow;
  logic                   sel_err;
  logic                   clr;
  logic [NPORT*LW-1:0]    level;

  modport master (
    output s_data, s_valid, req_in, clr,
    input  s_ready, io_in, underflow, sel_err, level
  );

  modport slave (
    input  s_data, s_valid, req_in, clr,
    output s_ready, io_in, underflow, sel_err, level
  );
endinterface

// File: rtl/in_feeder.sv
// Per-port sample FIFOs feeding a zero-latency processor read port.
// Each port is one in_feeder_lane; the top only decodes req_in and muxes the read data.
module in_feeder_lane #(
  parameter int NBITS = 19,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             rd,
  input  logic             clr,
  output logic [NBITS-1:0] rd_data,
  output logic             underflow,
  output logic [LW-1:0]    level
);
  logic [NBITS-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic [NBITS-1:0] last;
  logic             empty, push, pop;

  assign empty     = (count == '0);
  assign wr_ready  = (count != LW'(DEPTH));
  assign push      = wr_valid & wr_ready;
  // a push landing this cycle is not visible to a read in the same cycle
  assign pop       = rd & ~empty;
  assign rd_data   = empty ? last : mem[rd_ptr];
  assign level     = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last      <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= mem[rd_ptr];
      end
      count <= count + LW'(push) - LW'(pop);
      if (rd && empty) underflow <= 1'b1;
      else if (clr)    underflow <= 1'b0;
    end
  end

  // storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

module in_feeder #(
  parameter int NBITS = 19,
  parameter int NPORT = 4,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  in_feeder_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                        req_any, req_onehot, req_multi;
  logic [NPORT-1:0]            rd;
  logic [NPORT-1:0][NBITS-1:0] lane_data;
  logic                        sel_err_q;

  assign req_any    = (bus.req_in != '0);
  assign req_onehot = req_any && ((bus.req_in & (bus.req_in - NPORT'(1))) == '0);
  assign req_multi  = req_any && !req_onehot;
  // an illegal multi-bit select reads nothing and pops nothing
  assign rd         = req_onehot ? bus.req_in : '0;

  for (genvar g = 0; g < NPORT; g++) begin : g_lane
    in_feeder_lane #(.NBITS(NBITS), .DEPTH(DEPTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .wr_data   (bus.s_data[g*NBITS +: NBITS]),
      .wr_valid  (bus.s_valid[g]),
      .wr_ready  (bus.s_ready[g]),
      .rd        (rd[g]),
      .clr       (bus.clr),
      .rd_data   (lane_data[g]),
      .underflow (bus.underflow[g]),
      .level     (bus.level[g*LW +: LW])
    );
  end

  always_comb begin
    bus.io_in = '0;
    for (int k = 0; k < NPORT; k++)
      if (rd[k]) bus.io_in = bus.io_in | lane_data[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            sel_err_q <= 1'b0;
    else if (req_multi) sel_err_q <= 1'b1;
    else if (bus.clr)   sel_err_q <= 1'b0;
  end

  assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_in_feeder.sv
// Bench for in_feeder: directed scenarios followed by random traffic, all checked
// against a queue-based model of the per-port FIFOs and sticky flags.
module tb_in_feeder;
  localparam int NBITS = 19;
  localparam int NPORT = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  in_feeder_if #(.NBITS(NBITS), .NPORT(NPORT), .DEPTH(DEPTH)) bus ();
  in_feeder #(.NBITS(NBITS), .NPORT(NPORT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [NBITS-1:0] mq [NPORT][$];
  logic [NBITS-1:0] mlast [NPORT];
  logic [NPORT-1:0] muf;
  logic             mse;
  logic [NBITS-1:0] obs_io;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NPORT; k++) begin
      mq[k].delete();
      mlast[k] = '0;
    end
    muf = '0;
    mse = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < NPORT; k++)
      chk({tag, "_level"}, 64'(bus.level[k*LW +: LW]), 64'(mq[k].size()));
    chk({tag, "_underflow"}, 64'(bus.underflow), 64'(muf));
    chk({tag, "_sel_err"}, 64'(bus.sel_err), 64'(mse));
  endtask

  function automatic logic [NPORT-1:0] sel(input int p);
    logic [NPORT-1:0] m;
    m = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [NPORT*NBITS-1:0] at(input int p, input int val);
    logic [NPORT*NBITS-1:0] r;
    r = '0;
    r[p*NBITS +: NBITS] = NBITS'(val);
    return r;
  endfunction

  // Called at posedge+1: drive, check the combinational read, take the edge, check state.
  task automatic step(input logic [NPORT-1:0] v, input logic [NPORT*NBITS-1:0] d,
                      input logic [NPORT-1:0] req, input logic c);
    logic [NBITS-1:0] exp_io;
    logic [NPORT-1:0] exp_rdy;
    int n;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.req_in  = req;
    bus.clr     = c;
    #2;
    n = $countones(req);
    exp_io = '0;
    for (int k = 0; k < NPORT; k++) begin
      exp_rdy[k] = (mq[k].size() < DEPTH);
      if (n == 1 && req[k]) exp_io = (mq[k].size() > 0) ? mq[k][0] : mlast[k];
    end
    obs_io = bus.io_in;
    chk("io_in", 64'(bus.io_in), 64'(exp_io));
    chk("s_ready", 64'(bus.s_ready), 64'(exp_rdy));
    @(posedge clk);
    if (c) begin
      muf = '0;
      mse = 1'b0;
    end
    if (n > 1) mse = 1'b1;
    for (int k = 0; k < NPORT; k++) begin
      if (n == 1 && req[k]) begin
        if (mq[k].size() > 0) mlast[k] = mq[k].pop_front();
        else                  muf[k] = 1'b1;
      end
      if (v[k] && exp_rdy[k]) mq[k].push_back(d[k*NBITS +: NBITS]);
    end
    #1;
    check_state("step");
  endtask

  task automatic push(input int p, input int val);
    step(sel(p), at(p, val), '0, 1'b0);
  endtask

  task automatic rd(input int p);
    step('0, '0, sel(p), 1'b0);
  endtask

  initial begin
    logic [NPORT*NBITS-1:0] d;
    logic [NPORT-1:0]       req;
    int                     r;

    rst = 1'b1;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.req_in  = '0;
    bus.clr     = 1'b0;
    model_reset();
    #12;
    chk("reset_s_ready", 64'(bus.s_ready), 64'(4'b1111));
    check_state("reset");

    // release just after an edge; the very next edge must take a push
    @(posedge clk); #1;
    rst = 1'b0;

    // basic order on port 0
    push(0, 5);
    push(0, -7);
    push(0, 262143);
    rd(0); chk("order_0", 64'(obs_io), 64'(19'd5));
    rd(0); chk("order_1", 64'(obs_io), 64'(19'h7FFF9));
    rd(0); chk("order_2", 64'(obs_io), 64'(19'h3FFFF));
    chk("order_level0", 64'(bus.level[0 +: LW]), 64'(0));

    // fill port 2, stall a 5th push, then alternate across pointer wrap
    for (int i = 0; i < 4; i++) push(2, 11 + i);
    chk("full_ready2", 64'(bus.s_ready[2]), 64'(0));
    push(2, 99);
    chk("full_level2", 64'(bus.level[2*LW +: LW]), 64'(4));
    for (int i = 0; i < 3; i++) begin
      rd(2);
      chk("wrap_pop", 64'(obs_io), 64'(11 + i));
      push(2, 20 + i);
    end
    rd(2); chk("wrap_d0", 64'(obs_io), 64'(14));
    rd(2); chk("wrap_d1", 64'(obs_io), 64'(20));
    rd(2); chk("wrap_d2", 64'(obs_io), 64'(21));
    rd(2); chk("wrap_d3", 64'(obs_io), 64'(22));

    // underflow returns the last popped value
    push(1, 100);
    rd(1); chk("uf_first", 64'(obs_io), 64'(100));
    rd(1); chk("uf_repeat", 64'(obs_io), 64'(100));
    chk("uf_flag", 64'(bus.underflow), 64'(4'b0010));
    step('0, '0, '0, 1'b1);
    chk("uf_clr", 64'(bus.underflow), 64'(0));

    // multi-bit select: no data, no pops
    push(0, 1);
    push(1, 2);
    step('0, '0, 4'b0011, 1'b0);
    chk("sel_io", 64'(obs_io), 64'(0));
    chk("sel_flag", 64'(bus.sel_err), 64'(1));
    // a new set condition wins over a clear in the same cycle
    step('0, '0, 4'b0101, 1'b1);
    chk("sel_set_wins", 64'(bus.sel_err), 64'(1));
    step('0, '0, '0, 1'b1);
    rd(0); rd(1);

    // push into empty port 3 while reading it
    step(4'b1000, at(3, 42), 4'b1000, 1'b0);
    chk("ep_io", 64'(obs_io), 64'(0));
    chk("ep_uf3", 64'(bus.underflow[3]), 64'(1));
    chk("ep_level3", 64'(bus.level[3*LW +: LW]), 64'(1));
    rd(3); chk("ep_next", 64'(obs_io), 64'(42));
    step('0, '0, '0, 1'b1);

    // reset mid-stream with levels 2,1,3,4
    step(4'b1111, at(0, 1) | at(1, 2) | at(2, 3) | at(3, 4), '0, 1'b0);
    step(4'b1101, at(0, 5) | at(2, 6) | at(3, 7), '0, 1'b0);
    step(4'b1100, at(2, 8) | at(3, 9), '0, 1'b0);
    step(4'b1000, at(3, 10), '0, 1'b0);
    chk("pre_rst_level3", 64'(bus.level[3*LW +: LW]), 64'(4));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_s_ready", 64'(bus.s_ready), 64'(4'b1111));
    check_state("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    rd(0);
    chk("post_rst_io", 64'(obs_io), 64'(0));
    chk("post_rst_uf0", 64'(bus.underflow[0]), 64'(1));
    step('0, '0, '0, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NPORT; k++) d[k*NBITS +: NBITS] = NBITS'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)      req = sel($urandom_range(0, NPORT - 1));
      else if (r < 8) req = '0;
      else            req = NPORT'($urandom);
      step(NPORT'($urandom), d, req, ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
